// File: rtl/softmax_normalize.sv
// Softmax normaliser: latches an exp vector and its sum, computes 1/sum by restoring division,
// then streams exp[i]*recip out one element per cycle. Define SOFTMAX_NORM_ROUND_EN for round-half-up.
module softmax_normalize #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_vec,
  input  logic [DATA_WIDTH-1:0]            in_sum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [$clog2(NUM_INPUTS)-1:0]    out_idx,
  output logic                             out_last
);
  localparam int unsigned IDX_W  = $clog2(NUM_INPUTS);
  localparam int unsigned CNT_W  = $clog2(FRAC_BITS + 1);
  localparam int unsigned RCP_W  = FRAC_BITS + 1;
  localparam int unsigned PROD_W = DATA_WIDTH + FRAC_BITS + 1;
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1) << FRAC_BITS;
  localparam logic [DATA_WIDTH:0]   REM_INIT = (DATA_WIDTH + 1)'(1) << (FRAC_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] vec_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH:0]   rem_q;
  logic [RCP_W-1:0]      recip_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept, xfer, div_done, rem_ge;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [IDX_W-1:0]      load_idx;
  logic [DATA_WIDTH-1:0] load_elem, elem_res;
  logic [PROD_W-1:0]     prod;
`ifdef SOFTMAX_NORM_ROUND_EN
  logic [PROD_W-1:0]     prod_rnd, scaled;
`endif

  assign in_ready = (state_q == S_IDLE);

  always_comb begin
    accept    = in_valid && (state_q == S_IDLE);
    xfer      = out_valid && out_ready;
    div_done  = (state_q == S_DIV) && (cnt_q == CNT_W'(FRAC_BITS));
    // 2^(2F) has a single set bit: start with the bits above the quotient range (2^(F-1)),
    // so only F+1 shift/subtract steps remain and all shifted-in dividend bits are zero.
    rem_shift = {rem_q[DATA_WIDTH-1:0], 1'b0};
    rem_ge    = (rem_shift >= {1'b0, sum_q});
    load_idx  = out_valid ? (out_idx + IDX_W'(1)) : '0;
    load_elem = vec_q[load_idx];
    prod      = PROD_W'(load_elem) * PROD_W'(recip_q);
`ifdef SOFTMAX_NORM_ROUND_EN
    prod_rnd  = prod + (PROD_W'(1) << (FRAC_BITS - 1));
    scaled    = prod_rnd >> FRAC_BITS;
    elem_res  = (scaled > PROD_W'(load_elem)) ? load_elem : scaled[DATA_WIDTH-1:0];
`else
    elem_res  = prod[FRAC_BITS +: DATA_WIDTH];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_DIV;
      S_DIV:   if (div_done) state_d = S_OUT;
      S_OUT:   if (xfer && out_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) vec_q[i] <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      recip_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) vec_q[i] <= in_vec[i*DATA_WIDTH +: DATA_WIDTH];
        sum_q   <= (in_sum < ONE) ? ONE : in_sum;
        rem_q   <= REM_INIT;
        recip_q <= '0;
        cnt_q   <= '0;
      end
      if (state_q == S_DIV) begin
        rem_q   <= rem_ge ? (rem_shift - {1'b0, sum_q}) : rem_shift;
        recip_q <= {recip_q[RCP_W-2:0], rem_ge};
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      // First OUT cycle loads element 0; afterwards each transfer loads the next one.
      if (state_q == S_OUT) begin
        if (!out_valid || (xfer && !out_last)) begin
          out_valid <= 1'b1;
          out_data  <= elem_res;
          out_idx   <= load_idx;
          out_last  <= (load_idx == IDX_W'(NUM_INPUTS - 1));
        end else if (xfer) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_idx   <= '0;
          out_last  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_softmax_normalize.sv
// Directed bench for softmax_normalize (N=4, DW=16, F=8): table vectors plus stall, reset and
// back-to-back sequences.
module tb_softmax_normalize;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned FB = 8;

  typedef struct packed {
    logic [3:0][15:0] v;
    logic [15:0]      sum;
    logic [3:0][15:0] e;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, out_last;
  logic [N*DW-1:0] in_vec;
  logic [DW-1:0]   in_sum, out_data;
  logic [1:0]      out_idx;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  vec_t        tbl [3];

  always #5 clk = ~clk;

  softmax_normalize #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] v0, v1, v2, v3, s, e0, e1, e2, e3);
    vec_t t;
    t.v = {v3, v2, v1, v0};
    t.sum = s;
    t.e = {e3, e2, e1, e0};
    return t;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic apply(input vec_t t, input bit hold);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_vec   = t.v;
    in_sum   = t.sum;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check(name, lat, 32'd10);
  endtask

  task automatic expect_elem(input vec_t t, input int i);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_data", {16'd0, out_data}, {16'd0, t.e[i]});
    check("out_idx", {30'd0, out_idx}, i);
    check("out_last", {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic recv_from(input vec_t t, input int first);
    for (int i = first; i < 4; i++) begin
      expect_elem(t, i);
      @(negedge clk);
    end
    check("out_valid_after_last", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_last", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_out_data"}, {16'd0, out_data}, 32'd0);
    check({name, "_out_idx"}, {30'd0, out_idx}, 32'd0);
    check({name, "_out_last"}, {31'd0, out_last}, 32'd0);
  endtask

  initial begin
    tbl[0] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0400,
                16'h0040, 16'h0040, 16'h0040, 16'h0040);
`ifdef SOFTMAX_NORM_ROUND_EN
    tbl[1] = mk(16'h0100, 16'h0200, 16'h0180, 16'h0000, 16'h0300,
                16'h0055, 16'h00AA, 16'h0080, 16'h0000);
`else
    tbl[1] = mk(16'h0100, 16'h0200, 16'h0180, 16'h0000, 16'h0300,
                16'h0055, 16'h00AA, 16'h007F, 16'h0000);
`endif
    tbl[2] = mk(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0080,
                16'h0010, 16'h0020, 16'h0030, 16'h0040);

    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_sum = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, continuous out_ready
    for (int k = 0; k < 3; k++) begin
      apply(tbl[k], 1'b0);
      wait_out("latency");
      recv_from(tbl[k], 0);
    end

    // Stall at idx1 for 5 cycles, with ignored in_valid pulses
    apply(tbl[1], 1'b0);
    wait_out("latency_stall");
    expect_elem(tbl[1], 0);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_elem(tbl[1], 1);
      in_valid = (k % 2 == 0);
      in_vec   = tbl[2].v;
      in_sum   = tbl[2].sum;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    recv_from(tbl[1], 1);
    repeat (12) @(negedge clk);
    check("no_output_from_ignored_pulses", {31'd0, out_valid}, 32'd0);

    // Reset during DIV
    apply(tbl[0], 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_div");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_output_after_rst_div", {31'd0, out_valid}, 32'd0);

    // Reset at idx2 of OUT
    apply(tbl[1], 1'b0);
    wait_out("latency_pre_rst");
    expect_elem(tbl[1], 0);
    @(negedge clk);
    expect_elem(tbl[1], 1);
    @(negedge clk);
    expect_elem(tbl[1], 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_out");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_output_after_rst_out", {31'd0, out_valid}, 32'd0);
    apply(tbl[0], 1'b0);
    wait_out("latency_post_rst");
    recv_from(tbl[0], 0);

    // Back-to-back with in_valid held high
    apply(tbl[0], 1'b1);
    in_vec = tbl[2].v;
    in_sum = tbl[2].sum;
    wait_out("latency_b2b_a");
    recv_from(tbl[0], 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("latency_b2b_b");
    recv_from(tbl[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
